// File: rtl/cmn_plru_bank.sv
// Multi-set tree pseudo-LRU replacement bank.
// Holds WAYS-1 tree bits per set; handshaked victim lookup, flush sequencer.
module cmn_plru_bank #(
  parameter int SETS  = 8,
  parameter int WAYS  = 4,
  parameter int SET_W = (SETS > 1) ? $clog2(SETS) : 1,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_vld,
  input  logic [SET_W-1:0] acc_set,
  input  logic [WAY_W-1:0] acc_way,
  input  logic             vic_req_vld,
  output logic             vic_req_rdy,
  input  logic [SET_W-1:0] vic_req_set,
  input  logic [WAYS-1:0]  vic_req_valid,
  input  logic [WAYS-1:0]  vic_req_lock,
  output logic             vic_rsp_vld,
  input  logic             vic_rsp_rdy,
  output logic [WAYS-1:0]  vic_rsp_way,
  output logic             vic_rsp_none,
  input  logic             vic_rsp_touch,
  input  logic             flush_req,
  output logic             busy
);

  localparam int TW = WAYS - 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [TW-1:0]    tree_q [SETS];
  logic [TW-1:0]    tree_d [SETS];
  logic [0:0]       state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic [SET_W-1:0] rsp_set_q, rsp_set_d;
  logic [WAYS-1:0]  rsp_way_q, rsp_way_d;
  logic             rsp_none_q, rsp_none_d;

  logic [TW-1:0]    rd_tree;
  logic [WAY_W-1:0] cmt_way;
  logic             req_fire;
  logic             cmt_ok;
  logic             acc_ok;

  // Mark way w most recent: each node on its path points away from it.
  function automatic logic [TW-1:0] f_touch(
    input logic [TW-1:0]    t,
    input logic [WAY_W-1:0] w
  );
    logic [TW-1:0] r;
    int            node;
    int            dir;
    r = t;
    for (int l = 0; l < WAY_W; l++) begin
      node = (1 << l) - 1 + (int'(w) >> (WAY_W - l));
      dir  = (int'(w) >> (WAY_W - 1 - l)) & 1;
      r    = r & ~(TW'(1) << node);
      if (dir == 0) r = r | (TW'(1) << node);
    end
    return r;
  endfunction

  // Lowest invalid unlocked way first, else a lock-aware tree walk.
  function automatic logic [WAYS-1:0] f_pick(
    input logic [TW-1:0]   t,
    input logic [WAYS-1:0] cand,
    input logic [WAYS-1:0] vld
  );
    logic [WAYS-1:0] inv;
    logic [WAYS-1:0] r;
    logic [WAYS-1:0] sh;
    logic [WAYS-1:0] lm;
    logic [TW-1:0]   ts;
    logic            lh;
    logic            rh;
    logic            go_r;
    int              p;
    int              node;
    int              half;
    inv = cand & ~vld;
    r   = '0;
    if (|inv) begin
      r = inv & (~inv + WAYS'(1));
    end else if (|cand) begin
      p = 0;
      for (int l = 0; l < WAY_W; l++) begin
        half = WAYS >> (l + 1);
        node = (1 << l) - 1 + p;
        lm   = {WAYS{1'b1}} >> (WAYS - half);
        sh   = cand >> (p * 2 * half);
        lh   = |(sh & lm);
        rh   = |((sh >> half) & lm);
        ts   = t >> node;
        go_r = ts[0] ? rh : ~lh;
        p    = 2 * p + int'(go_r);
      end
      r = WAYS'(1) << p;
    end
    return r;
  endfunction

  assign busy         = (state_q == ST_FLUSH);
  assign vic_req_rdy  = ~busy & (~rsp_vld_q | vic_rsp_rdy);
  assign vic_rsp_vld  = rsp_vld_q;
  assign vic_rsp_way  = rsp_way_q;
  assign vic_rsp_none = rsp_none_q;

  assign req_fire = vic_req_vld & vic_req_rdy;
  assign acc_ok   = acc_vld & ~busy;
  assign cmt_ok   = rsp_vld_q & vic_rsp_rdy & vic_rsp_touch
                  & ~rsp_none_q & ~busy;

  // Read the requested set; out-of-range sets read as all-zero.
  always_comb begin
    rd_tree = '0;
    for (int s = 0; s < SETS; s++) begin
      if (vic_req_set == SET_W'(s)) rd_tree = tree_q[s];
    end
  end

  // One-hot registered victim back to a way index.
  always_comb begin
    cmt_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (rsp_way_q[i]) cmt_way = WAY_W'(i);
    end
  end

  // Tree update: commit touch, then access touch, flush clear last.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      tree_d[s] = tree_q[s];
      if (cmt_ok && rsp_set_q == SET_W'(s))
        tree_d[s] = f_touch(tree_d[s], cmt_way);
      if (acc_ok && acc_set == SET_W'(s))
        tree_d[s] = f_touch(tree_d[s], acc_way);
      if (busy && cnt_q == SET_W'(s))
        tree_d[s] = '0;
    end
  end

  // Response register: load on request accept, drop on response accept.
  always_comb begin
    rsp_vld_d  = rsp_vld_q;
    rsp_set_d  = rsp_set_q;
    rsp_way_d  = rsp_way_q;
    rsp_none_d = rsp_none_q;
    if (req_fire) begin
      rsp_vld_d  = 1'b1;
      rsp_set_d  = vic_req_set;
      rsp_way_d  = f_pick(rd_tree, ~vic_req_lock, vic_req_valid);
      rsp_none_d = &vic_req_lock;
    end else if (vic_rsp_rdy) begin
      rsp_vld_d  = 1'b0;
    end
  end

  // Flush sequencer: walk every set once, one per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == SET_W'(SETS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SET_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_set_q  <= '0;
      rsp_way_q  <= '0;
      rsp_none_q <= 1'b0;
    end else begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= tree_d[s];
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_set_q  <= rsp_set_d;
      rsp_way_q  <= rsp_way_d;
      rsp_none_q <= rsp_none_d;
    end
  end

endmodule

// File: tb/tb_cmn_plru_bank.sv
// Bench for cmn_plru_bank: directed scenarios plus random traffic
// against a range-walking tree PLRU reference model.
module tb_cmn_plru_bank;

  localparam int SETS  = 8;
  localparam int WAYS  = 4;
  localparam int SET_W = 3;
  localparam int WAY_W = 2;

  logic             clk;
  logic             rst;
  logic             acc_vld;
  logic [SET_W-1:0] acc_set;
  logic [WAY_W-1:0] acc_way;
  logic             vic_req_vld;
  logic             vic_req_rdy;
  logic [SET_W-1:0] vic_req_set;
  logic [WAYS-1:0]  vic_req_valid;
  logic [WAYS-1:0]  vic_req_lock;
  logic             vic_rsp_vld;
  logic             vic_rsp_rdy;
  logic [WAYS-1:0]  vic_rsp_way;
  logic             vic_rsp_none;
  logic             vic_rsp_touch;
  logic             flush_req;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  bit m_tree [SETS][WAYS-1];
  bit m_vld;
  int m_set;
  int m_way;
  bit m_none;
  bit m_busy;
  int m_cnt;

  cmn_plru_bank #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk           (clk),
    .rst           (rst),
    .acc_vld       (acc_vld),
    .acc_set       (acc_set),
    .acc_way       (acc_way),
    .vic_req_vld   (vic_req_vld),
    .vic_req_rdy   (vic_req_rdy),
    .vic_req_set   (vic_req_set),
    .vic_req_valid (vic_req_valid),
    .vic_req_lock  (vic_req_lock),
    .vic_rsp_vld   (vic_rsp_vld),
    .vic_rsp_rdy   (vic_rsp_rdy),
    .vic_rsp_way   (vic_rsp_way),
    .vic_rsp_none  (vic_rsp_none),
    .vic_rsp_touch (vic_rsp_touch),
    .flush_req     (flush_req),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_touch(int s, int w);
    int lo;
    int hi;
    int n;
    int mid;
    if (s >= SETS) return;
    lo = 0;
    hi = WAYS;
    n  = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin
        m_tree[s][n] = 1'b1;
        hi = mid;
        n  = 2 * n + 1;
      end else begin
        m_tree[s][n] = 1'b0;
        lo = mid;
        n  = 2 * n + 2;
      end
    end
  endfunction

  function automatic int m_pick(int s, logic [WAYS-1:0] vm,
                                logic [WAYS-1:0] lm);
    int lo;
    int hi;
    int n;
    int mid;
    bit lh;
    bit rh;
    bit b;
    for (int w = 0; w < WAYS; w++) begin
      if (!lm[w] && !vm[w]) return w;
    end
    if (&lm) return -1;
    lo = 0;
    hi = WAYS;
    n  = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      lh  = 1'b0;
      rh  = 1'b0;
      for (int w = lo; w < hi; w++) begin
        if (!lm[w]) begin
          if (w < mid) lh = 1'b1;
          else rh = 1'b1;
        end
      end
      b = (s < SETS) ? m_tree[s][n] : 1'b0;
      if ((b && rh) || (!b && !lh)) begin
        lo = mid;
        n  = 2 * n + 2;
      end else begin
        hi = mid;
        n  = 2 * n + 1;
      end
    end
    return lo;
  endfunction

  task automatic step();
    bit rdy_m;
    bit cmt;
    int sel;
    #1;
    rdy_m = !m_busy && (!m_vld || vic_rsp_rdy);
    check("req_rdy", vic_req_rdy, rdy_m);
    sel = m_pick(vic_req_set, vic_req_valid, vic_req_lock);
    cmt = m_vld && vic_rsp_rdy && vic_rsp_touch && !m_none && !m_busy;
    if (cmt) m_touch(m_set, m_way);
    if (acc_vld && !m_busy) m_touch(acc_set, acc_way);
    if (m_busy) begin
      for (int w = 0; w < WAYS - 1; w++) m_tree[m_cnt][w] = 1'b0;
      m_cnt++;
      if (m_cnt == SETS) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end
    end else if (flush_req) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end
    if (vic_req_vld && rdy_m) begin
      m_vld  = 1'b1;
      m_set  = vic_req_set;
      m_none = (sel < 0);
      m_way  = sel;
    end else if (vic_rsp_rdy) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    check("rsp_vld", vic_rsp_vld, m_vld);
    check("busy", busy, m_busy);
    if (m_vld) begin
      check("rsp_way", vic_rsp_way, m_none ? 0 : (1 << m_way));
      check("rsp_none", vic_rsp_none, m_none);
    end
  endtask

  task automatic do_req(int s, logic [3:0] v, logic [3:0] l,
                        bit touch, logic [3:0] exp, string tag);
    vic_req_vld   = 1'b1;
    vic_req_set   = SET_W'(s);
    vic_req_valid = v;
    vic_req_lock  = l;
    vic_rsp_rdy   = 1'b1;
    vic_rsp_touch = 1'b0;
    step();
    check(tag, vic_rsp_way, exp);
    vic_req_vld   = 1'b0;
    vic_rsp_touch = touch;
    step();
    vic_rsp_touch = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    acc_vld       = 1'b0;
    acc_set       = '0;
    acc_way       = '0;
    vic_req_vld   = 1'b0;
    vic_req_set   = '0;
    vic_req_valid = '1;
    vic_req_lock  = '0;
    vic_rsp_rdy   = 1'b1;
    vic_rsp_touch = 1'b0;
    flush_req     = 1'b0;
    m_vld  = 1'b0;
    m_set  = 0;
    m_way  = 0;
    m_none = 1'b0;
    m_busy = 1'b0;
    m_cnt  = 0;
    @(posedge clk);
    #1;
    check("rst_rsp_vld", vic_rsp_vld, 0);
    check("rst_rsp_way", vic_rsp_way, 0);
    check("rst_none", vic_rsp_none, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", vic_req_rdy, 1);
    rst = 1'b0;

    do_req(3, 4'b1111, 4'b0000, 1'b1, 4'b0001, "first_victim");
    check("first_none", vic_rsp_none, 0);
    do_req(3, 4'b1111, 4'b0000, 1'b1, 4'b0100, "after_touch0");
    do_req(3, 4'b1111, 4'b0000, 1'b0, 4'b0010, "after_touch2");
    do_req(3, 4'b1011, 4'b0000, 1'b0, 4'b0100, "invalid_first");
    do_req(3, 4'b1111, 4'b1111, 1'b1, 4'b0000, "all_locked");
    do_req(3, 4'b1111, 4'b0000, 1'b0, 4'b0010, "locked_no_touch");

    acc_vld = 1'b1;
    acc_set = 3'd3;
    acc_way = 2'd3;
    step();
    acc_way = 2'd1;
    step();
    acc_vld = 1'b0;
    do_req(3, 4'b1111, 4'b0000, 1'b0, 4'b0100, "pref_way2");
    do_req(3, 4'b1111, 4'b0100, 1'b0, 4'b1000, "sibling_fb");
    do_req(3, 4'b1111, 4'b1100, 1'b0, 4'b0001, "cross_left");

    vic_req_vld   = 1'b1;
    vic_req_set   = 3'd3;
    vic_req_valid = 4'b1110;
    vic_req_lock  = 4'b0000;
    step();
    check("same_pick", vic_rsp_way, 4'b0001);
    vic_req_vld   = 1'b0;
    vic_rsp_touch = 1'b1;
    acc_vld       = 1'b1;
    acc_set       = 3'd3;
    acc_way       = 2'd3;
    step();
    vic_rsp_touch = 1'b0;
    acc_vld       = 1'b0;
    do_req(3, 4'b1111, 4'b0000, 1'b0, 4'b0010, "same_set_win");

    vic_req_vld   = 1'b1;
    vic_req_set   = 3'd5;
    vic_req_valid = 4'b1110;
    step();
    vic_req_vld   = 1'b0;
    vic_rsp_touch = 1'b1;
    acc_vld       = 1'b1;
    acc_set       = 3'd6;
    acc_way       = 2'd3;
    step();
    vic_rsp_touch = 1'b0;
    acc_vld       = 1'b0;
    do_req(5, 4'b1111, 4'b0000, 1'b0, 4'b0100, "diff_set_cmt");
    do_req(6, 4'b1111, 4'b0000, 1'b0, 4'b0001, "diff_set_acc");

    for (int s = 0; s < SETS; s++) begin
      acc_vld = 1'b1;
      acc_set = SET_W'(s);
      acc_way = WAY_W'($urandom_range(0, WAYS - 1));
      step();
    end
    acc_vld   = 1'b0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    check("flush_busy", busy, 1);
    for (int i = 0; i < SETS; i++) begin
      acc_vld       = 1'b1;
      acc_set       = SET_W'($urandom_range(0, SETS - 1));
      acc_way       = WAY_W'($urandom_range(0, WAYS - 1));
      vic_req_vld   = 1'b1;
      vic_req_set   = SET_W'($urandom_range(0, SETS - 1));
      vic_req_valid = 4'b1111;
      flush_req     = 1'b1;
      check("flush_rdy", vic_req_rdy, 0);
      step();
      check("flush_len", busy, (i < SETS - 1) ? 1 : 0);
    end
    acc_vld     = 1'b0;
    vic_req_vld = 1'b0;
    flush_req   = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      do_req(s, 4'b1111, 4'b0000, 1'b0, 4'b0001, "post_flush");
    end

    vic_req_vld   = 1'b1;
    vic_req_set   = 3'd2;
    vic_req_valid = 4'b1111;
    vic_req_lock  = 4'b0000;
    step();
    vic_req_vld = 1'b0;
    vic_rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vic_req_set   = SET_W'($urandom_range(0, SETS - 1));
      vic_req_lock  = WAYS'($urandom);
      step();
      check("hold_vld", vic_rsp_vld, 1);
      check("hold_way", vic_rsp_way, 4'b0001);
    end
    vic_rsp_rdy = 1'b1;
    step();

    for (int i = 0; i < 3000; i++) begin
      acc_vld       = ($urandom_range(0, 1) == 1);
      acc_set       = SET_W'($urandom);
      acc_way       = WAY_W'($urandom);
      vic_req_vld   = ($urandom_range(0, 1) == 1);
      vic_req_set   = SET_W'($urandom);
      vic_req_valid = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '1;
      vic_req_lock  = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '0;
      vic_rsp_rdy   = ($urandom_range(0, 3) != 0);
      vic_rsp_touch = ($urandom_range(0, 1) == 1);
      flush_req     = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
